// File: rtl/odometer_scan_host.sv
// Tester-side scan master for the odometer chip: WRITE shifts a config word in (capturing the
// old chain into CFG_ECHO) then pulses LOAD, TRIG pulses MEAS_TRIG, READ shifts the counter chain out.
module odometer_scan_host #(
  parameter int CFG_BITS = 16,
  parameter int CNT_BITS = 32,
  parameter int DIV      = 4,
  parameter int TRIG_CYC = 8
) (
  input  logic                CLK,
  input  logic                RESETB,
  input  logic                CMD_VALID,
  input  logic [1:0]          CMD,
  output logic                CMD_READY,
  input  logic [CFG_BITS-1:0] CFG_DATA,
  output logic [CFG_BITS-1:0] CFG_ECHO,
  output logic [CNT_BITS-1:0] RD_DATA,
  output logic                BUSY,
  output logic                DONE,
  output logic                SCANIN_CLK,
  output logic                SCANIN_DIN,
  output logic                LOAD,
  output logic                MEAS_TRIG,
  output logic                SCANOUT_CLK,
  input  logic                SCANIN_DOUT,
  input  logic                SCANOUT_DOUT
);

  localparam int MAXB = (CFG_BITS > CNT_BITS) ? CFG_BITS : CNT_BITS;
  localparam int BW   = $clog2(MAXB + 1);
  localparam int PW   = $clog2(DIV + 1);
  localparam int TW   = $clog2(TRIG_CYC + 1);

  localparam logic [PW-1:0] PH_LAST   = PW'(DIV - 1);
  localparam logic [BW-1:0] CFG_LAST  = BW'(CFG_BITS - 1);
  localparam logic [BW-1:0] CNT_LAST  = BW'(CNT_BITS - 1);
  localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WSHIFT,
    S_WLOAD,
    S_TRIG,
    S_RSHIFT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       ph_q, ph_d;
  logic                hi_q, hi_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [TW-1:0]       trg_q, trg_d;
  logic [CFG_BITS-1:0] sh_q, sh_d;
  logic [CFG_BITS-1:0] echo_q, echo_d;
  logic [CNT_BITS-1:0] rd_q, rd_d;

  logic low_end;
  logic bit_end;
  logic timed;

  // low_end is the sample point (just before the rising edge); bit_end closes a bit period
  assign low_end = !hi_q && (ph_q == PH_LAST);
  assign bit_end =  hi_q && (ph_q == PH_LAST);
  assign timed   = (state_q == S_WSHIFT) || (state_q == S_WLOAD) || (state_q == S_RSHIFT);

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    hi_d    = hi_q;
    bit_d   = bit_q;
    trg_d   = trg_q;
    sh_d    = sh_q;
    echo_d  = echo_q;
    rd_d    = rd_q;

    if (timed) begin
      if (ph_q == PH_LAST) begin
        ph_d = '0;
        hi_d = !hi_q;
      end else begin
        ph_d = ph_q + PW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        ph_d  = '0;
        hi_d  = 1'b0;
        bit_d = '0;
        trg_d = '0;
        if (CMD_VALID) begin
          case (CMD)
            2'b00: begin
              state_d = S_WSHIFT;
              sh_d    = CFG_DATA;
            end
            2'b01:   state_d = S_TRIG;
            2'b10:   state_d = S_RSHIFT;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_WSHIFT: begin
        if (low_end) echo_d = {echo_q[CFG_BITS-2:0], SCANIN_DOUT};
        if (bit_end) begin
          sh_d = sh_q << 1;
          if (bit_q == CFG_LAST) begin
            bit_d   = '0;
            state_d = S_WLOAD;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_WLOAD: begin
        if (bit_end) state_d = S_DONE;
      end
      S_TRIG: begin
        if (trg_q == TRIG_LAST) begin
          trg_d   = '0;
          state_d = S_DONE;
        end else begin
          trg_d = trg_q + TW'(1);
        end
      end
      S_RSHIFT: begin
        if (low_end) rd_d = {rd_q[CNT_BITS-2:0], SCANOUT_DOUT};
        if (bit_end) begin
          if (bit_q == CNT_LAST) begin
            bit_d   = '0;
            state_d = S_DONE;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      hi_q    <= 1'b0;
      bit_q   <= '0;
      trg_q   <= '0;
      sh_q    <= '0;
      echo_q  <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      hi_q    <= hi_d;
      bit_q   <= bit_d;
      trg_q   <= trg_d;
      sh_q    <= sh_d;
      echo_q  <= echo_d;
      rd_q    <= rd_d;
    end
  end

  // Pins decode straight from reset-cleared registers, so RESETB drops them at once
  assign CMD_READY   = (state_q == S_IDLE);
  assign BUSY        = (state_q == S_WSHIFT) || (state_q == S_WLOAD) ||
                       (state_q == S_TRIG)   || (state_q == S_RSHIFT);
  assign DONE        = (state_q == S_DONE);
  assign SCANIN_CLK  = (state_q == S_WSHIFT) && hi_q;
  assign SCANIN_DIN  = (state_q == S_WSHIFT) && sh_q[CFG_BITS-1];
  assign LOAD        = (state_q == S_WLOAD);
  assign MEAS_TRIG   = (state_q == S_TRIG);
  assign SCANOUT_CLK = (state_q == S_RSHIFT) && hi_q;
  assign CFG_ECHO    = echo_q;
  assign RD_DATA     = rd_q;

endmodule

// File: tb/tb_odometer_scan_host.sv
// Directed bench for odometer_scan_host with simple chip-side scan chain models.
module tb_odometer_scan_host;

  logic        CLK = 1'b0;
  logic        RESETB;
  logic        CMD_VALID;
  logic [1:0]  CMD;
  logic        CMD_READY;
  logic [7:0]  CFG_DATA;
  logic [7:0]  CFG_ECHO;
  logic [31:0] RD_DATA;
  logic        BUSY, DONE;
  logic        SCANIN_CLK, SCANIN_DIN, LOAD, MEAS_TRIG, SCANOUT_CLK;
  logic        SCANIN_DOUT, SCANOUT_DOUT;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  odometer_scan_host #(.CFG_BITS(8), .CNT_BITS(32), .DIV(2), .TRIG_CYC(8)) dut (
    .CLK(CLK), .RESETB(RESETB), .CMD_VALID(CMD_VALID), .CMD(CMD), .CMD_READY(CMD_READY),
    .CFG_DATA(CFG_DATA), .CFG_ECHO(CFG_ECHO), .RD_DATA(RD_DATA), .BUSY(BUSY), .DONE(DONE),
    .SCANIN_CLK(SCANIN_CLK), .SCANIN_DIN(SCANIN_DIN), .LOAD(LOAD), .MEAS_TRIG(MEAS_TRIG),
    .SCANOUT_CLK(SCANOUT_CLK), .SCANIN_DOUT(SCANIN_DOUT), .SCANOUT_DOUT(SCANOUT_DOUT)
  );

  // Chip models: config chain shifts on SCANIN_CLK rise; readout chain presents cnt_word MSB-first
  logic [7:0]  chain = 8'h3C;
  logic [31:0] cnt_word;
  logic [4:0]  sout_idx = 5'd0;
  always @(posedge SCANIN_CLK) chain <= {chain[6:0], SCANIN_DIN};
  always @(posedge SCANOUT_CLK) sout_idx <= sout_idx + 5'd1;
  assign SCANIN_DOUT  = chain[7];
  assign SCANOUT_DOUT = cnt_word[5'd31 - sout_idx];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  int         r_done, r_sin, r_sout, r_load, r_trig, r_first, r_bad;
  logic       r_busy_ok, r_done_ok, r_ready_after;
  logic [7:0] r_din, r_echo;
  logic [31:0] r_rd;

  // Issue one command, then watch pins per cycle; c counts cycles after the accept edge
  task automatic run_cmd(input logic [1:0] cmd, input logic [7:0] cfg);
    logic psin, psout;
    int c;
    r_done = -1; r_sin = 0; r_sout = 0; r_load = 0; r_trig = 0; r_first = 0; r_bad = 0;
    r_busy_ok = 1'b1; r_done_ok = 1'b0; r_din = 8'h00; psin = 1'b0; psout = 1'b0;
    @(negedge CLK);
    CMD = cmd; CFG_DATA = cfg; CMD_VALID = 1'b1;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    c = 1;
    while (c < 400) begin
      if (DONE) begin
        r_done    = c;
        r_done_ok = !BUSY && !CMD_READY;
        r_echo    = CFG_ECHO;
        r_rd      = RD_DATA;
        break;
      end
      r_busy_ok = r_busy_ok && BUSY && !CMD_READY;
      if (SCANIN_CLK && !psin) begin
        r_sin++;
        r_din = {r_din[6:0], SCANIN_DIN};
        if (r_first == 0) r_first = c;
      end
      if (SCANOUT_CLK && !psout) begin
        r_sout++;
        if (r_first == 0) r_first = c;
      end
      if (LOAD) r_load++;
      if (MEAS_TRIG) r_trig++;
      if ((LOAD && (SCANIN_CLK || SCANIN_DIN)) || (SCANIN_CLK && SCANOUT_CLK)) r_bad++;
      psin = SCANIN_CLK; psout = SCANOUT_CLK;
      @(negedge CLK);
      c++;
    end
    @(negedge CLK);
    r_ready_after = CMD_READY;
  endtask

  typedef struct {
    logic [1:0]  cmd;
    logic [7:0]  cfg;
    logic [31:0] cnt;
    int          done_c, sin_e, sout_e, load_c, trig_c, first;
    logic [7:0]  echo;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int dones, rdy, bsy, souts, c;
    logic pso;

    vecs[0] = '{2'b00, 8'hA5, 32'h0,         37,  8,  0, 4, 0, 3, 8'h3C, 32'h0};
    vecs[1] = '{2'b01, 8'h00, 32'h0,          9,  0,  0, 0, 8, 0, 8'h3C, 32'h0};
    vecs[2] = '{2'b10, 8'h00, 32'hDEADBEEF, 129,  0, 32, 0, 0, 3, 8'h3C, 32'hDEADBEEF};
    vecs[3] = '{2'b00, 8'h5A, 32'h0,         37,  8,  0, 4, 0, 3, 8'hA5, 32'hDEADBEEF};
    vecs[4] = '{2'b10, 8'h00, 32'h01234567, 129,  0, 32, 0, 0, 3, 8'hA5, 32'h01234567};

    RESETB = 1'b0; CMD_VALID = 1'b0; CMD = 2'b00; CFG_DATA = 8'h00; cnt_word = 32'h0;
    repeat (3) @(negedge CLK);
    chk("reset_ready", CMD_READY, 1);
    chk("reset_status", {BUSY, DONE}, 0);
    chk("reset_pins", {SCANIN_CLK, SCANIN_DIN, LOAD, MEAS_TRIG, SCANOUT_CLK}, 0);
    chk("reset_data", {CFG_ECHO, RD_DATA}, 0);
    RESETB = 1'b1;
    bsy = 0;
    repeat (6) begin
      @(negedge CLK);
      if (BUSY || DONE || !CMD_READY || SCANIN_CLK || SCANOUT_CLK || LOAD || MEAS_TRIG) bsy++;
    end
    chk("idle_quiet", bsy, 0);

    for (int i = 0; i < 5; i++) begin
      cnt_word = vecs[i].cnt;
      run_cmd(vecs[i].cmd, vecs[i].cfg);
      chk("done_cycle",  r_done,  vecs[i].done_c);
      chk("busy_window", r_busy_ok, 1);
      chk("done_flags",  r_done_ok, 1);
      chk("ready_after", r_ready_after, 1);
      chk("scanin_edges",  r_sin,  vecs[i].sin_e);
      chk("scanout_edges", r_sout, vecs[i].sout_e);
      chk("load_cycles",   r_load, vecs[i].load_c);
      chk("trig_cycles",   r_trig, vecs[i].trig_c);
      chk("first_rise",    r_first, vecs[i].first);
      chk("pin_rules",     r_bad, 0);
      chk("cfg_echo",      r_echo, vecs[i].echo);
      chk("rd_data",       r_rd,   vecs[i].rd);
      if (vecs[i].cmd == 2'b00) chk("din_sequence", r_din, vecs[i].cfg);
    end

    // WRITE with a READ request held while busy, then reserved code 11 in idle
    dones = 0; rdy = 0; bsy = 0; souts = 0; pso = 1'b0;
    @(negedge CLK);
    CMD = 2'b00; CFG_DATA = 8'hC3; CMD_VALID = 1'b1;
    @(negedge CLK);
    CMD = 2'b10;
    c = 1;
    while (!DONE && c < 400) begin
      if (SCANOUT_CLK && !pso) souts++;
      pso = SCANOUT_CLK;
      @(negedge CLK);
      c++;
    end
    chk("hold_done_cycle", c, 37);
    chk("hold_echo", CFG_ECHO, 8'h5A);
    if (DONE) dones++;
    CMD = 2'b11;
    repeat (6) begin
      @(negedge CLK);
      if (DONE) dones++;
      if (CMD_READY) rdy++;
      if (BUSY) bsy++;
      if (SCANOUT_CLK && !pso) souts++;
      pso = SCANOUT_CLK;
    end
    CMD_VALID = 1'b0;
    chk("single_done", dones, 1);
    chk("reserved_ready", rdy, 6);
    chk("reserved_busy", bsy, 0);
    chk("no_scanout", souts, 0);
    chk("reserved_hold", {CFG_ECHO, RD_DATA}, {8'h5A, 32'h01234567});

    // READ aborted by reset during the high phase of bit 3
    cnt_word = 32'hFFFF0000;
    @(negedge CLK);
    CMD = 2'b10; CMD_VALID = 1'b1;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    repeat (14) @(negedge CLK);
    chk("abort_clk_before", SCANOUT_CLK, 1);
    RESETB = 1'b0;
    #1;
    chk("abort_clk_low", SCANOUT_CLK, 0);
    chk("abort_busy", {BUSY, DONE}, 0);
    dones = 0;
    repeat (3) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    RESETB = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    chk("abort_no_done", dones, 0);
    chk("abort_cleared", {CFG_ECHO, RD_DATA}, 0);

    run_cmd(2'b00, 8'h0F);
    chk("post_done_cycle", r_done, 37);
    chk("post_echo", r_echo, 8'hC3);
    chk("post_din", r_din, 8'h0F);
    chk("post_load", r_load, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
